// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single memory port between the instruction fetch
// unit (IFU) and the load/store unit (LSU). One requester is granted at a
// time. Its request is latched and mem_reqValid is held until the memory
// answers. The answer is then routed back to the granted requester only.
// Responses that arrive while idle are dropped.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to add a busy-cycle counter.
// On expiry the counter answers the granted requester with all-ones data and
// pulses mem_err.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = 0,    // 0: LSU has fixed priority, 1: round-robin
  parameter int TIMEOUT  = 255   // watchdog limit, only with MEM_ARB_TIMEOUT_EN
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                ifu_reqValid,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_respValid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_reqValid,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_respValid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_reqValid,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_respValid,
  input  logic [DATA_W-1:0]   mem_rdata,
`ifdef MEM_ARB_TIMEOUT_EN
  output logic                mem_err,
`endif
  output logic                busy
);

  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IFU_BUSY = 2'd1,
    LSU_BUSY = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic                last_lsu_reg, last_lsu_next;   // 1: last grant went to the LSU
  logic                req_valid_reg, req_valid_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic                wen_reg, wen_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [MASK_W-1:0]   wmask_reg, wmask_next;
  logic                grant_lsu, grant_ifu, txn_done;
  logic                timeout_hit;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // The watchdog expires on the busy cycle that would bring the count up to TIMEOUT.
  // A real response in that same cycle takes precedence.
  assign timeout_hit = (state_reg != IDLE) && !mem_respValid &&
                       (cnt_reg == CNT_W'(TIMEOUT - 1));
  assign mem_err     = timeout_hit;

  // Held at zero while idle, so it always starts from zero on entry to a busy state.
  always_comb begin
    cnt_next = cnt_reg;
    if (state_reg == IDLE)
      cnt_next = '0;
    else if (!mem_respValid)
      cnt_next = cnt_reg + 1'b1;
  end

  // Watchdog counter register.
  always_ff @(posedge clock) begin
    if (!reset_n)
      cnt_reg <= '0;
    else
      cnt_reg <= cnt_next;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Arbitration, next-state and response routing.
  always_comb begin
    state_next     = state_reg;
    last_lsu_next  = last_lsu_reg;
    req_valid_next = req_valid_reg;
    addr_next      = addr_reg;
    wen_next       = wen_reg;
    wdata_next     = wdata_reg;
    wmask_next     = wmask_reg;
    grant_lsu      = 1'b0;
    grant_ifu      = 1'b0;
    txn_done       = 1'b0;
    ifu_respValid  = 1'b0;
    lsu_respValid  = 1'b0;
    case (state_reg)
      IDLE: begin
        // When both requesters are pending, fixed mode favours the LSU.
        // Round-robin mode favours whichever requester was not granted last.
        if (lsu_reqValid && (!ifu_reqValid || ARB_MODE == 0 || !last_lsu_reg))
          grant_lsu = 1'b1;
        else if (ifu_reqValid)
          grant_ifu = 1'b1;

        if (grant_lsu) begin
          state_next     = LSU_BUSY;
          last_lsu_next  = 1'b1;
          req_valid_next = 1'b1;
          addr_next      = lsu_addr;
          wen_next       = lsu_wen;
          wdata_next     = lsu_wdata;
          wmask_next     = lsu_wmask;
        end else if (grant_ifu) begin
          state_next     = IFU_BUSY;
          last_lsu_next  = 1'b0;
          req_valid_next = 1'b1;
          addr_next      = ifu_addr;
          wen_next       = 1'b0;
          wdata_next     = '0;
          wmask_next     = '0;
        end
      end
      IFU_BUSY, LSU_BUSY: begin
        txn_done      = mem_respValid || timeout_hit;
        ifu_respValid = txn_done && (state_reg == IFU_BUSY);
        lsu_respValid = txn_done && (state_reg == LSU_BUSY);
        if (txn_done) begin
          state_next     = IDLE;
          req_valid_next = 1'b0;
        end
      end
      default: begin
        state_next     = IDLE;
        req_valid_next = 1'b0;
      end
    endcase
  end

  // State and grant-history registers. A reset abandons any outstanding transfer.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      last_lsu_reg  <= 1'b0;
      req_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      last_lsu_reg  <= last_lsu_next;
      req_valid_reg <= req_valid_next;
    end
  end

  // Latched request fields, stable for the whole transaction.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      addr_reg  <= '0;
      wen_reg   <= 1'b0;
      wdata_reg <= '0;
      wmask_reg <= '0;
    end else begin
      addr_reg  <= addr_next;
      wen_reg   <= wen_next;
      wdata_reg <= wdata_next;
      wmask_reg <= wmask_next;
    end
  end

  assign mem_reqValid = req_valid_reg;
  assign mem_addr     = addr_reg;
  assign mem_wen      = wen_reg;
  assign mem_wdata    = wdata_reg;
  assign mem_wmask    = wmask_reg;
  assign busy         = (state_reg != IDLE);
  assign ifu_rdata    = timeout_hit ? '1 : mem_rdata;
  assign lsu_rdata    = timeout_hit ? '1 : mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: instance 0 runs fixed LSU priority and instance 1 runs
// round-robin. A transaction-level model predicts each grant, the latched
// fields and the response routing. The checks cover directed scenarios and
// randomized rounds. Define MEM_ARB_TIMEOUT_EN to add the watchdog scenario.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_n    [2];
  logic          ifu_req    [2];
  logic [AW-1:0] ifu_addr   [2];
  logic          ifu_resp   [2];
  logic [DW-1:0] ifu_rdata  [2];
  logic          lsu_req    [2];
  logic [AW-1:0] lsu_addr   [2];
  logic          lsu_wen    [2];
  logic [DW-1:0] lsu_wdata  [2];
  logic [MW-1:0] lsu_wmask  [2];
  logic          lsu_resp   [2];
  logic [DW-1:0] lsu_rdata  [2];
  logic          mem_req    [2];
  logic [AW-1:0] mem_addr   [2];
  logic          mem_wen    [2];
  logic [DW-1:0] mem_wdata  [2];
  logic [MW-1:0] mem_wmask  [2];
  logic          mem_resp   [2];
  logic [DW-1:0] mem_rdata  [2];
  logic          busy       [2];
`ifdef MEM_ARB_TIMEOUT_EN
  logic          mem_err    [2];
`endif

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    mem_arbiter #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
`ifdef MEM_ARB_TIMEOUT_EN
      .TIMEOUT (4),
`endif
      .ARB_MODE(gi)
    ) u_dut (
      .clock        (clock),
      .reset_n      (reset_n[gi]),
      .ifu_reqValid (ifu_req[gi]),
      .ifu_addr     (ifu_addr[gi]),
      .ifu_respValid(ifu_resp[gi]),
      .ifu_rdata    (ifu_rdata[gi]),
      .lsu_reqValid (lsu_req[gi]),
      .lsu_addr     (lsu_addr[gi]),
      .lsu_wen      (lsu_wen[gi]),
      .lsu_wdata    (lsu_wdata[gi]),
      .lsu_wmask    (lsu_wmask[gi]),
      .lsu_respValid(lsu_resp[gi]),
      .lsu_rdata    (lsu_rdata[gi]),
      .mem_reqValid (mem_req[gi]),
      .mem_addr     (mem_addr[gi]),
      .mem_wen      (mem_wen[gi]),
      .mem_wdata    (mem_wdata[gi]),
      .mem_wmask    (mem_wmask[gi]),
      .mem_respValid(mem_resp[gi]),
      .mem_rdata    (mem_rdata[gi]),
`ifdef MEM_ARB_TIMEOUT_EN
      .mem_err      (mem_err[gi]),
`endif
      .busy         (busy[gi])
    );
  end

  int n_checks = 0;
  int n_errors = 0;
  bit last_lsu [2];   // model: 1 when the most recent grant went to the LSU

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs(input int k);
    ifu_req[k]   = 1'b0;
    ifu_addr[k]  = '0;
    lsu_req[k]   = 1'b0;
    lsu_addr[k]  = '0;
    lsu_wen[k]   = 1'b0;
    lsu_wdata[k] = '0;
    lsu_wmask[k] = '0;
    mem_resp[k]  = 1'b0;
    mem_rdata[k] = '0;
  endtask

  task automatic do_reset(input int k);
    reset_n[k] = 1'b0;
    clear_inputs(k);
    tick();
    tick();
    check_eq("rst_mem_reqValid", 64'(mem_req[k]), 64'(0));
    check_eq("rst_busy", 64'(busy[k]), 64'(0));
    check_eq("rst_mem_addr", 64'(mem_addr[k]), 64'(0));
    check_eq("rst_mem_wen", 64'(mem_wen[k]), 64'(0));
    check_eq("rst_mem_wdata", 64'(mem_wdata[k]), 64'(0));
    check_eq("rst_mem_wmask", 64'(mem_wmask[k]), 64'(0));
    reset_n[k]  = 1'b1;
    last_lsu[k] = 1'b0;
    $display("dut%0d reset", k);
  endtask

  // Raise the requested transfers in an idle cycle and serve up to n_txn of them.
  // With keep set, granted requesters stay asserted, which presents a new request each time.
  task automatic run_round(input int k, input bit want_ifu, input bit want_lsu,
                           input int n_txn, input bit keep, input int dly0,
                           input logic [DW-1:0] rd0, input logic [AW-1:0] ia,
                           input logic [AW-1:0] la, input logic lw,
                           input logic [DW-1:0] ld, input logic [MW-1:0] lm);
    bit ip, lp;
    ip = want_ifu;
    lp = want_lsu;
    ifu_req[k]   = ip;
    ifu_addr[k]  = ia;
    lsu_req[k]   = lp;
    lsu_addr[k]  = la;
    lsu_wen[k]   = lw;
    lsu_wdata[k] = ld;
    lsu_wmask[k] = lm;
    for (int t = 0; t < n_txn && (ip || lp); t++) begin
      bit            win_lsu;
      logic [AW-1:0] ea;
      logic          ew;
      logic [DW-1:0] ed;
      logic [MW-1:0] em;
      logic [DW-1:0] rd;
      int            d;
      win_lsu = lp && (!ip || k == 0 || !last_lsu[k]);
      ea = win_lsu ? lsu_addr[k] : ifu_addr[k];
      ew = win_lsu ? lsu_wen[k] : 1'b0;
      ed = lsu_wdata[k];
      em = win_lsu ? lsu_wmask[k] : '0;
      tick();
      check_eq("grant_mem_reqValid", 64'(mem_req[k]), 64'(1));
      check_eq("grant_busy", 64'(busy[k]), 64'(1));
      check_eq("grant_mem_addr", 64'(mem_addr[k]), 64'(ea));
      check_eq("grant_mem_wen", 64'(mem_wen[k]), 64'(ew));
      check_eq("grant_mem_wmask", 64'(mem_wmask[k]), 64'(em));
      if (win_lsu)
        check_eq("grant_mem_wdata", 64'(mem_wdata[k]), 64'(ed));
      last_lsu[k] = win_lsu;
      // Disturb the granted requester's inputs: the latched fields must not follow.
      if (win_lsu) begin
        lsu_addr[k]  = $urandom;
        lsu_wdata[k] = $urandom;
      end else begin
        ifu_addr[k] = $urandom;
      end
      d  = (t == 0 && dly0 >= 0) ? dly0 : int'($urandom_range(0, 3));
      rd = (t == 0 && dly0 >= 0) ? rd0 : DW'($urandom);
      for (int c = 0; c < d; c++) begin
        check_eq("wait_ifu_respValid", 64'(ifu_resp[k]), 64'(0));
        check_eq("wait_lsu_respValid", 64'(lsu_resp[k]), 64'(0));
        check_eq("wait_mem_reqValid", 64'(mem_req[k]), 64'(1));
        check_eq("wait_mem_addr", 64'(mem_addr[k]), 64'(ea));
        if (win_lsu)
          check_eq("wait_mem_wdata", 64'(mem_wdata[k]), 64'(ed));
        tick();
      end
      mem_resp[k]  = 1'b1;
      mem_rdata[k] = rd;
      #1;
      check_eq("resp_ifu_respValid", 64'(ifu_resp[k]), 64'(!win_lsu));
      check_eq("resp_lsu_respValid", 64'(lsu_resp[k]), 64'(win_lsu));
      if (win_lsu)
        check_eq("resp_lsu_rdata", 64'(lsu_rdata[k]), 64'(rd));
      else
        check_eq("resp_ifu_rdata", 64'(ifu_rdata[k]), 64'(rd));
      $display("dut%0d txn %s addr=%h wen=%0d wmask=%h rdata=%h wait=%0d",
               k, win_lsu ? "LSU" : "IFU", ea, ew, em, rd, d);
      tick();
      mem_resp[k] = 1'b0;
      check_eq("after_busy", 64'(busy[k]), 64'(0));
      check_eq("after_mem_reqValid", 64'(mem_req[k]), 64'(0));
      if (t == n_txn - 1) begin
        ip = 1'b0;
        lp = 1'b0;
      end else if (!keep) begin
        if (win_lsu) lp = 1'b0;
        else         ip = 1'b0;
      end
      ifu_req[k] = ip;
      lsu_req[k] = lp;
    end
  endtask

  // Reset while the IFU transfer is outstanding; a late response must be dropped.
  task automatic reset_mid(input int k);
    ifu_req[k]  = 1'b1;
    ifu_addr[k] = 32'h0000_1234;
    tick();
    check_eq("mid_busy_before", 64'(busy[k]), 64'(1));
    reset_n[k] = 1'b0;
    ifu_req[k] = 1'b0;
    tick();
    check_eq("mid_mem_reqValid", 64'(mem_req[k]), 64'(0));
    check_eq("mid_busy", 64'(busy[k]), 64'(0));
    reset_n[k]  = 1'b1;
    last_lsu[k] = 1'b0;
    tick();
    mem_resp[k]  = 1'b1;
    mem_rdata[k] = 32'hCAFE_F00D;
    #1;
    check_eq("late_ifu_respValid", 64'(ifu_resp[k]), 64'(0));
    check_eq("late_lsu_respValid", 64'(lsu_resp[k]), 64'(0));
    tick();
    mem_resp[k] = 1'b0;
    check_eq("late_busy", 64'(busy[k]), 64'(0));
    $display("dut%0d txn reset-abandon late response dropped", k);
  endtask

  // A response with no transfer outstanding must not reach either requester.
  task automatic stray_resp(input int k);
    mem_resp[k]  = 1'b1;
    mem_rdata[k] = 32'h1111_2222;
    #1;
    check_eq("stray_ifu_respValid", 64'(ifu_resp[k]), 64'(0));
    check_eq("stray_lsu_respValid", 64'(lsu_resp[k]), 64'(0));
    tick();
    mem_resp[k] = 1'b0;
    check_eq("stray_busy", 64'(busy[k]), 64'(0));
    check_eq("stray_mem_reqValid", 64'(mem_req[k]), 64'(0));
    $display("dut%0d txn stray response ignored", k);
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic timeout_case(input int k);
    lsu_req[k]   = 1'b1;
    lsu_addr[k]  = 32'h0000_0200;
    lsu_wen[k]   = 1'b0;
    lsu_wdata[k] = '0;
    lsu_wmask[k] = '0;
    tick();
    last_lsu[k] = 1'b1;
    for (int c = 1; c < 4; c++) begin
      check_eq("to_wait_lsu_respValid", 64'(lsu_resp[k]), 64'(0));
      check_eq("to_wait_mem_err", 64'(mem_err[k]), 64'(0));
      tick();
    end
    check_eq("to_lsu_respValid", 64'(lsu_resp[k]), 64'(1));
    check_eq("to_ifu_respValid", 64'(ifu_resp[k]), 64'(0));
    check_eq("to_mem_err", 64'(mem_err[k]), 64'(1));
    check_eq("to_lsu_rdata", 64'(lsu_rdata[k]), 64'(32'hFFFF_FFFF));
    tick();
    lsu_req[k] = 1'b0;
    check_eq("to_busy", 64'(busy[k]), 64'(0));
    mem_resp[k] = 1'b1;
    #1;
    check_eq("to_late_lsu_respValid", 64'(lsu_resp[k]), 64'(0));
    tick();
    mem_resp[k] = 1'b0;
    $display("dut%0d txn LSU watchdog timeout", k);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      reset_n[k]  = 1'b0;
      last_lsu[k] = 1'b0;
      clear_inputs(k);
    end
    do_reset(0);
    do_reset(1);

    // IFU fetch answered on the 4th busy cycle.
    run_round(0, 1'b1, 1'b0, 1, 1'b0, 3, 32'h0000_0013, 32'h8000_0000,
              '0, 1'b0, '0, '0);
    // Simultaneous requests, fixed priority: LSU store first, then IFU.
    run_round(0, 1'b1, 1'b1, 2, 1'b0, 1, 32'h0000_0000, 32'h8000_0004,
              32'h0000_0100, 1'b1, 32'hDEAD_BEEF, 4'hF);
    // Round-robin with both requesters held: LSU, IFU, LSU, IFU.
    do_reset(1);
    run_round(1, 1'b1, 1'b1, 4, 1'b1, -1, '0, 32'h8000_0100,
              32'h0000_0400, 1'b1, 32'h0123_4567, 4'h3);

    reset_mid(0);
    stray_resp(1);

    for (int r = 0; r < 24; r++) begin
      int  k;
      bit  wi, wl, kp;
      k  = r % 2;
      wi = 1'($urandom_range(0, 1));
      wl = 1'($urandom_range(0, 1));
      if (!wi && !wl) wl = 1'b1;
      kp = 1'($urandom_range(0, 1));
      run_round(k, wi, wl, kp ? 3 : 2, kp, -1, '0, AW'($urandom), AW'($urandom),
                1'($urandom_range(0, 1)), DW'($urandom), MW'($urandom_range(0, 15)));
    end

`ifdef MEM_ARB_TIMEOUT_EN
    timeout_case(0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
    $finish;
  end

endmodule
